// File: rtl/ap_ctrl_driver.sv
// Purpose : ap_ctrl_hs/ap_ctrl_chain initiator; issues a counted run of starts into an
//           HLS core, keeps up to DEPTH in flight, and reports per-transaction latency.
// Latency : ap_start may rise the cycle after cmd accept; a result is valid the cycle
//           after its completion; done_pulse follows the cycle the last result drains.
// Backpr. : res_ready_i low holds ap_continue_o low, so the core holds ap_done and
//           no result is ever dropped; issue stops while DEPTH are in flight.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   cmd_valid_i/cmd_ready_o       run request; cmd_count_i = transactions to issue
//   ap_start_o/ap_ready_i         issue handshake to the core
//   ap_done_i/ap_continue_o       completion handshake from the core
//   res_valid_o/res_ready_i       result port: res_latency_o, res_index_o
//   busy_o, done_pulse_o          run in progress, one-cycle end-of-run strobe
//   total_cycles_o                cmd accept to run end, held until next run ends
//   err_o                         sticky protocol error
module ap_ctrl_driver #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_count_i,
  output logic             ap_start_o,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  output logic             ap_continue_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [TS_W-1:0]  res_latency_o,
  output logic [CNT_W-1:0] res_index_o,
  output logic             busy_o,
  output logic             done_pulse_o,
  output logic [TS_W-1:0]  total_cycles_o,
  output logic             err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IF_W  = $clog2(DEPTH) + 1;
  localparam logic [IF_W-1:0]  DEPTH_V  = IF_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e           state_q;
  logic [TS_W-1:0]  tick_q;
  logic [TS_W-1:0]  start_tick_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] completed_q;
  logic [IF_W-1:0]  inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]  fifo_q [DEPTH];
  logic             res_valid_q;
  logic [TS_W-1:0]  res_latency_q;
  logic [CNT_W-1:0] res_index_q;
  logic             done_pulse_q;
  logic [TS_W-1:0]  total_cycles_q;
  logic             err_q;

  logic issue, comp_raw, comp_ok, bypass, push, pop, last_comp, flush_exit, err_evt;
  logic [TS_W-1:0] comp_lat;

  // Issue/continue are decoded from registered state only, so a reset drops
  // them immediately and there is no combinational path from ap_ready/ap_done.
  assign ap_start_o    = (state_q == S_RUN) && (issued_q < count_q) && (inflight_q < DEPTH_V);
  assign ap_continue_o = (state_q == S_RUN) && (!res_valid_q || res_ready_i);

  assign issue    = ap_start_o && ap_ready_i;
  assign comp_raw = ap_done_i && ap_continue_o;
  // A completion with nothing outstanding is only legal if it retires the
  // start issued in this very cycle; that one never touches the FIFO.
  assign comp_ok  = comp_raw && ((inflight_q != '0) || issue);
  assign bypass   = comp_ok && (inflight_q == '0);
  assign push     = issue && !bypass;
  assign pop      = comp_ok && !bypass;
  assign comp_lat = bypass ? '0 : (tick_q - fifo_q[rd_ptr_q]);

  assign last_comp  = comp_ok && ((completed_q + CNT_W'(1)) == count_q);
  assign flush_exit = (state_q == S_FLUSH) && (!res_valid_q || res_ready_i);

  assign err_evt = ((state_q == S_IDLE) && ap_done_i)
                 || (comp_raw && !comp_ok)
                 || (ap_ready_i && !ap_start_o);

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !comp_ok) begin
      inflight_d = inflight_q + IF_W'(1);
    end else if (!issue && comp_ok) begin
      inflight_d = inflight_q - IF_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  // Issue-timestamp storage; emptiness is tracked by the pointers and inflight.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= tick_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      start_tick_q   <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      completed_q    <= '0;
      inflight_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      res_valid_q    <= 1'b0;
      res_latency_q  <= '0;
      res_index_q    <= '0;
      done_pulse_q   <= 1'b0;
      total_cycles_q <= '0;
      err_q          <= 1'b0;
    end else begin
      tick_q       <= tick_q + TS_W'(1);
      done_pulse_q <= 1'b0;
      inflight_q   <= inflight_d;

      if (err_evt) begin
        err_q <= 1'b1;
      end
      if (issue) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_d;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_d;
      end

      // A new completion wins over the consumer's ready in the same cycle;
      // that is safe because ap_continue already required the slot to free up.
      if (comp_ok) begin
        res_valid_q   <= 1'b1;
        res_latency_q <= comp_lat;
        res_index_q   <= completed_q;
        completed_q   <= completed_q + CNT_W'(1);
      end else if (res_ready_i) begin
        res_valid_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            count_q      <= cmd_count_i;
            start_tick_q <= tick_q;
            issued_q     <= '0;
            completed_q  <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            if (cmd_count_i == '0) begin
              done_pulse_q   <= 1'b1;
              total_cycles_q <= '0;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (last_comp) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_exit) begin
            state_q        <= S_IDLE;
            done_pulse_q   <= 1'b1;
            total_cycles_q <= tick_q - start_tick_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign res_valid_o    = res_valid_q;
  assign res_latency_o  = res_latency_q;
  assign res_index_o    = res_index_q;
  assign done_pulse_o   = done_pulse_q;
  assign total_cycles_o = total_cycles_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Purpose : directed bench for ap_ctrl_driver with a behavioural pipelined core.
// Latency : core model returns ap_done lat_cfg cycles after each accepted start.
// Backpr. : core model holds ap_done until ap_continue retires it.
module tb_ap_ctrl_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_count;
  logic        ap_start, ap_ready, ap_done, ap_continue;
  logic        res_valid, res_ready;
  logic [7:0]  res_latency;
  logic [15:0] res_index;
  logic        busy, done_pulse, err;
  logic [7:0]  total_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // Core model state
  int   cyc = 0;         // mirrors the DUT tick (unwrapped)
  int   lat_cfg = 5;
  int   due_q[$];
  int   inflight_m = 0;
  logic model_done = 1'b0;
  logic inj_done;
  logic saw_block = 1'b0;
  logic over_depth = 1'b0;
  int   res_lat_q[$];
  int   res_idx_q[$];

  ap_ctrl_driver #(.CNT_W(16), .TS_W(8), .DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_count_i    (cmd_count),
    .ap_start_o     (ap_start),
    .ap_ready_i     (ap_ready),
    .ap_done_i      (ap_done),
    .ap_continue_o  (ap_continue),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_latency_o  (res_latency),
    .res_index_o    (res_index),
    .busy_o         (busy),
    .done_pulse_o   (done_pulse),
    .total_cycles_o (total_cycles),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  assign ap_ready = ap_start;
  assign ap_done  = model_done | inj_done;

  // Observe handshakes using pre-edge values.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      due_q.delete();
      inflight_m = 0;
    end else begin
      if (res_valid && res_ready) begin
        res_lat_q.push_back(int'(res_latency));
        res_idx_q.push_back(int'(res_index));
      end
      if (busy && inflight_m == 4 && !ap_start) saw_block = 1'b1;
      if (ap_start && inflight_m >= 4) over_depth = 1'b1;
      if (model_done && ap_continue && due_q.size() > 0) begin
        void'(due_q.pop_front());
        inflight_m--;
      end
      if (ap_start && ap_ready) begin
        due_q.push_back(cyc + lat_cfg);
        inflight_m++;
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    model_done = rst_n && (due_q.size() > 0) && (due_q[0] <= cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({pfx, "_ap_start"}, 32'(ap_start), 0);
    chk({pfx, "_ap_cont"}, 32'(ap_continue), 0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done_pulse"}, 32'(done_pulse), 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_res_lat"}, 32'(res_latency), 0);
    chk({pfx, "_res_idx"}, 32'(res_index), 0);
    chk({pfx, "_total"}, 32'(total_cycles), 0);
  endtask

  task automatic run_cmd(input int cnt);
    cmd_count = cnt[15:0];
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done_pulse && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(done_pulse), 1);
  endtask

  task automatic clear_results();
    res_lat_q.delete();
    res_idx_q.delete();
  endtask

  function automatic int lat_at(input int i);
    return (i < res_lat_q.size()) ? res_lat_q[i] : -1;
  endfunction

  function automatic int idx_at(input int i);
    return (i < res_idx_q.size()) ? res_idx_q[i] : -1;
  endfunction

  initial begin
    int k;
    int bad_idx;
    int bad_lat;
    logic cont_seen;
    logic rv_drop;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_count = '0;
    res_ready = 1'b1;
    inj_done  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Timestamp wrap: first issue at tick 250, completion at tick 4.
    lat_cfg = 10;
    k = 0;
    while (cyc != 249 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wrap_sync", 32'(cyc), 249);
    clear_results();
    run_cmd(1);
    chk("wrap_start", 32'(ap_start), 1);
    wait_done(60, "wrap_done");
    chk("wrap_nres", 32'(res_lat_q.size()), 1);
    chk("wrap_lat", 32'(lat_at(0)), 10);
    chk("wrap_total", 32'(total_cycles), 12);
    chk("wrap_err", 32'(err), 0);

    // Reset with 3 transactions in flight.
    run_cmd(8);
    k = 0;
    while (inflight_m != 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mr_inflight", 32'(inflight_m), 3);
    chk("mr_start_before", 32'(ap_start), 1);
    rst_n = 1'b0;
    #1;
    check_reset("mr");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single transaction, core latency 5.
    lat_cfg = 5;
    clear_results();
    run_cmd(1);
    chk("one_cmd_ready", 32'(cmd_ready), 0);
    chk("one_busy", 32'(busy), 1);
    chk("one_start", 32'(ap_start), 1);
    wait_done(40, "one_done");
    chk("one_nres", 32'(res_lat_q.size()), 1);
    chk("one_lat", 32'(lat_at(0)), 5);
    chk("one_idx", 32'(idx_at(0)), 0);
    chk("one_total", 32'(total_cycles), 7);
    chk("one_busy_end", 32'(busy), 0);
    chk("one_err", 32'(err), 0);
    @(negedge clk);
    chk("one_pulse_width", 32'(done_pulse), 0);

    // Zero-length run.
    run_cmd(0);
    chk("zero_pulse", 32'(done_pulse), 1);
    chk("zero_start", 32'(ap_start), 0);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_total", 32'(total_cycles), 0);
    @(negedge clk);
    chk("zero_pulse_width", 32'(done_pulse), 0);
    chk("zero_start2", 32'(ap_start), 0);

    // Pipelined core II=1, latency 10, 8 transactions.
    lat_cfg = 10;
    clear_results();
    saw_block  = 1'b0;
    over_depth = 1'b0;
    run_cmd(8);
    wait_done(200, "pipe_done");
    chk("pipe_nres", 32'(res_lat_q.size()), 8);
    bad_idx = 0;
    bad_lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (idx_at(i) != i) bad_idx++;
      if (lat_at(i) != 10) bad_lat++;
    end
    chk("pipe_idx_bad", 32'(bad_idx), 0);
    chk("pipe_lat_bad", 32'(bad_lat), 0);
    chk("pipe_over_depth", 32'(over_depth), 0);
    chk("pipe_saw_block", 32'(saw_block), 1);
    chk("pipe_total", 32'(total_cycles), 26);

    // Same run with the result consumer stalled for 20 cycles.
    clear_results();
    run_cmd(8);
    k = 0;
    while (res_lat_q.size() != 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    res_ready = 1'b0;
    chk("stall_nres_pre", 32'(res_lat_q.size()), 2);
    k = 0;
    while (!res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    cont_seen = 1'b0;
    rv_drop   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ap_continue) cont_seen = 1'b1;
      if (!res_valid) rv_drop = 1'b1;
    end
    chk("stall_cont", 32'(cont_seen), 0);
    chk("stall_rv_held", 32'(rv_drop), 0);
    chk("stall_done_held", 32'(ap_done), 1);
    chk("stall_idx_held", 32'(res_index), 2);
    chk("stall_nres_mid", 32'(res_lat_q.size()), 2);
    res_ready = 1'b1;
    wait_done(200, "stall_done");
    chk("stall_nres", 32'(res_lat_q.size()), 8);
    bad_idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (idx_at(i) != i) bad_idx++;
    end
    chk("stall_idx_bad", 32'(bad_idx), 0);
    chk("stall_lat0", 32'(lat_at(0)), 10);

    // Spurious ap_done while idle sets a sticky error.
    chk("err_pre", 32'(err), 0);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    chk("err_set", 32'(err), 1);
    @(negedge clk);
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);
    lat_cfg = 5;
    clear_results();
    run_cmd(2);
    wait_done(60, "err_run_done");
    chk("err_run_nres", 32'(res_lat_q.size()), 2);
    chk("err_run_idx1", 32'(idx_at(1)), 1);
    chk("err_run_lat1", 32'(lat_at(1)), 5);
    chk("err_still", 32'(err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
